// File: rtl/link_fifo_drain.sv
// link_fifo_drain: read-side engine for the two-list link_fifo.
// Alternates between List A and List B with a per-visit pop quota, buffers
// popped words in a 2-entry registered output FIFO tagged with their source
// list, and keeps wrapping per-list pop counters.
module link_fifo_drain #(
  parameter int DATAWIDTH = 128,
  parameter int QUOTA     = 4,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  output logic                 rd_list,
  output logic                 rd_rdy,
  input  logic                 rd_vld,
  input  logic [DATAWIDTH-1:0] rdata,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_list,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [CNTW-1:0]      cnt_a,
  output logic [CNTW-1:0]      cnt_b,
  output logic                 busy
);

  // Quota count only ever holds 0..QUOTA-1; the pop that would reach QUOTA
  // switches lists and clears it instead.
  localparam int QW = $clog2(QUOTA + 1);
  localparam logic [QW-1:0] QUOTA_LAST = QW'(QUOTA - 1);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                rd_list_r;
  logic                rd_list_nxt_s;
  logic [QW-1:0]       quota_r;
  logic [QW-1:0]       quota_nxt_s;
  logic                enable_r;
  logic                rd_rdy_s;
  logic                pop_s;
  logic                take_s;

  // Output buffer: head entry drives the stream directly, tail is the second slot.
  logic [DATAWIDTH-1:0] head_data_r;
  logic                 head_list_r;
  logic                 head_vld_r;
  logic [DATAWIDTH-1:0] tail_data_r;
  logic                 tail_list_r;
  logic                 tail_vld_r;

  logic [CNTW-1:0]      cnt_a_r;
  logic [CNTW-1:0]      cnt_b_r;

  assign pop_s  = rd_rdy_s & rd_vld;
  assign take_s = head_vld_r & m_rdy;

  // Next-state, list selection, quota tracking and pop strobe
  always_comb begin
    state_nxt_s   = state_r;
    rd_list_nxt_s = rd_list_r;
    quota_nxt_s   = quota_r;
    rd_rdy_s      = 1'b0;
    case (state_r)
      SETTLE: begin
        // One quiet cycle so link_fifo sees a stable rd_list before popping.
        state_nxt_s = DRAIN;
      end
      DRAIN: begin
        // Only rd_vld is combinational here; enable and occupancy are registered.
        rd_rdy_s = enable_r & rd_vld & ~tail_vld_r;
        if ((rd_rdy_s && (quota_r == QUOTA_LAST)) || (enable_r && !rd_vld)) begin
          // Quota exhausted wins over continuing; an empty list also moves on.
          rd_list_nxt_s = ~rd_list_r;
          quota_nxt_s   = {QW{1'b0}};
          state_nxt_s   = SETTLE;
        end else if (rd_rdy_s) begin
          quota_nxt_s = quota_r + QW'(1);
        end else begin
          // Stalled by a full buffer or disabled: hold position and quota.
          quota_nxt_s = quota_r;
        end
      end
      default: begin
        state_nxt_s = SETTLE;
      end
    endcase
  end

  // FSM state, list select, quota count and registered enable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= SETTLE;
      rd_list_r <= 1'b1;
      quota_r   <= {QW{1'b0}};
      enable_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rd_list_r <= rd_list_nxt_s;
      quota_r   <= quota_nxt_s;
      enable_r  <= enable;
    end
  end

  // Two-entry output FIFO; a push never coincides with a full buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_data_r <= {DATAWIDTH{1'b0}};
      head_list_r <= 1'b0;
      head_vld_r  <= 1'b0;
      tail_data_r <= {DATAWIDTH{1'b0}};
      tail_list_r <= 1'b0;
      tail_vld_r  <= 1'b0;
    end else if (take_s) begin
      if (tail_vld_r) begin
        head_data_r <= tail_data_r;
        head_list_r <= tail_list_r;
        tail_vld_r  <= 1'b0;
      end else if (pop_s) begin
        head_data_r <= rdata;
        head_list_r <= rd_list_r;
      end else begin
        head_vld_r <= 1'b0;
      end
    end else if (pop_s) begin
      if (head_vld_r) begin
        tail_data_r <= rdata;
        tail_list_r <= rd_list_r;
        tail_vld_r  <= 1'b1;
      end else begin
        head_data_r <= rdata;
        head_list_r <= rd_list_r;
        head_vld_r  <= 1'b1;
      end
    end
  end

  // Per-list pop counters, wrapping without saturation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_a_r <= {CNTW{1'b0}};
      cnt_b_r <= {CNTW{1'b0}};
    end else if (pop_s) begin
      if (rd_list_r) begin
        cnt_a_r <= cnt_a_r + CNTW'(1);
      end else begin
        cnt_b_r <= cnt_b_r + CNTW'(1);
      end
    end
  end

  assign rd_list = rd_list_r;
  assign rd_rdy  = rd_rdy_s;
  assign m_data  = head_data_r;
  assign m_list  = head_list_r;
  assign m_vld   = head_vld_r;
  assign busy    = head_vld_r;
  assign cnt_a   = cnt_a_r;
  assign cnt_b   = cnt_b_r;

endmodule
